axis_stimulus_source: RTL

Synthesizable AXI4-Stream master that produces deterministic plaintext test traffic for the AES-256-CTR core. It sits upstream of the core's s_axis input, which places it at the opposite end of the stream from the ciphertext checker. Each frame is started by a single pulse and consists of a programmable number of words ending in tlast. The block can insert pseudo-random, reproducible tvalid gaps so that the core's back-pressure and bubble handling get exercised both in simulation and on hardware.

---
 rtl/axis_stimulus_source.sv | 130 +++++++++++++
 1 files changed

// File: rtl/axis_stimulus_source.sv
// AXI4-Stream plaintext source: emits frames of (seed + i) words, replicated across the bus,
// with optional reproducible tvalid gaps driven by an 8-bit LFSR.
module axis_stimulus_source #(
    parameter int DATA_WIDTH = 128,
    parameter int LEN_WIDTH  = 16,
    parameter int GAP_BITS   = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [LEN_WIDTH-1:0]  num_words,
    input  logic [31:0]           seed,
    input  logic                  gap_enable,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    output logic                  m_axis_tlast,
    input  logic                  m_axis_tready,
    output logic                  busy,
    output logic                  done,
    output logic [LEN_WIDTH-1:0]  words_sent,
    output logic [1:0]            fsm_state
);

    localparam int REPS = DATA_WIDTH / 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t               state;
    logic [LEN_WIDTH-1:0] len_q;
    logic [LEN_WIDTH-1:0] idx;
    logic [31:0]          seed_q;
    logic                 gap_en_q;
    logic [7:0]           lfsr;
    logic [GAP_BITS-1:0]  gap_cnt;

    logic [7:0]           lfsr_adv;
    logic [LEN_WIDTH-1:0] idx_next;
    logic [31:0]          word_next;
    logic [GAP_BITS-1:0]  gap_len;
    logic                 beat;

    // Handshake: a beat transfers on a rising edge where tvalid && tready; once tvalid is
    // raised, tvalid/tdata/tlast stay frozen until that beat transfers.
    assign beat      = m_axis_tvalid && m_axis_tready;
    assign lfsr_adv  = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    assign idx_next  = idx + LEN_WIDTH'(1);
    assign word_next = seed_q + 32'(idx_next);
    assign gap_len   = lfsr_adv[GAP_BITS-1:0];
    assign fsm_state = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            len_q         <= '0;
            idx           <= '0;
            seed_q        <= '0;
            gap_en_q      <= 1'b0;
            lfsr          <= 8'hE1;
            gap_cnt       <= '0;
            m_axis_tdata  <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            words_sent    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        lfsr       <= 8'hE1;
                        words_sent <= '0;
                        if (num_words != '0) begin
                            len_q         <= num_words;
                            seed_q        <= seed;
                            gap_en_q      <= gap_enable;
                            idx           <= '0;
                            m_axis_tdata  <= {REPS{seed}};
                            m_axis_tvalid <= 1'b1;
                            m_axis_tlast  <= (num_words == LEN_WIDTH'(1));
                            busy          <= 1'b1;
                            state         <= SEND;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                SEND: begin
                    if (beat) begin
                        words_sent <= words_sent + LEN_WIDTH'(1);
                        if (m_axis_tlast) begin
                            m_axis_tvalid <= 1'b0;
                            m_axis_tlast  <= 1'b0;
                            busy          <= 1'b0;
                            done          <= 1'b1;
                            state         <= IDLE;
                        end else begin
                            // Next word is preloaded even when a gap follows; tvalid hides it.
                            idx          <= idx_next;
                            m_axis_tdata <= {REPS{word_next}};
                            m_axis_tlast <= (idx_next == len_q - LEN_WIDTH'(1));
                            if (gap_en_q) begin
                                lfsr <= lfsr_adv;
                            end
                            if (gap_en_q && (gap_len != '0)) begin
                                m_axis_tvalid <= 1'b0;
                                gap_cnt       <= gap_len;
                                state         <= GAP;
                            end
                        end
                    end
                end
                GAP: begin
                    if (gap_cnt == GAP_BITS'(1)) begin
                        m_axis_tvalid <= 1'b1;
                        state         <= SEND;
                    end else begin
                        gap_cnt <= gap_cnt - GAP_BITS'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
